// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope command protocol: FSM encoding,
// command codes and capture depth.
package oscilo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_FINISH  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [7:0] CMD_21 = 8'h21;
    localparam logic [7:0] CMD_22 = 8'h22;
    localparam logic [7:0] CMD_23 = 8'h23;
    localparam logic [7:0] CMD_24 = 8'h24;
    localparam logic [7:0] CMD_25 = 8'h25;
    localparam logic [7:0] CMD_31 = 8'h31;
    localparam logic [7:0] CMD_32 = 8'h32;
    localparam logic [7:0] CMD_71 = 8'h71;
    localparam logic [7:0] CMD_72 = 8'h72;

    localparam int SAMPLE_DEPTH = 256;

    // Clamp a requested argument count to what the block can hold.
    function automatic logic [2:0] sat_arg_cnt(input logic [2:0] n, input logic [2:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/cmd_initiator.sv
// Host emulator: sends a command plus argument bytes to a UART transmitter
// and gathers a fixed-length reply with checksum and inactivity timeout.
module cmd_initiator
    import oscilo_pkg::*;
#(
    parameter int MAX_ARGS = 4,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  activate,
    input  logic [7:0]            cmd,
    input  logic [2:0]            arg_cnt,
    input  logic [8*MAX_ARGS-1:0] args,
    input  logic [8:0]            reply_len,
    output logic                  done,
    output logic                  timeout,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_active,
    input  logic                  tx_done,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [7:0]            reply_data,
    output logic                  reply_valid,
    output logic [8:0]            reply_cnt,
    output logic [7:0]            checksum,
    output logic [2:0]            fsm_state
);

    localparam int              TO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [2:0]      MAX_A   = 3'(MAX_ARGS);

    state_e                  state;
    logic [7:0]              cmd_q;
    logic [8*MAX_ARGS-1:0]   args_q;
    logic [2:0]              arg_cnt_q;
    logic [2:0]              tx_idx;
    logic [8:0]              reply_len_q;
    logic                    rx_prev;
    logic [TO_W-1:0]         to_cnt;

    logic rx_rise;
    logic rx_active;
    logic rx_accept;

    assign rx_rise   = rx_ready & ~rx_prev;
    assign rx_active = (state != ST_IDLE) && (state != ST_DONE);
    assign rx_accept = rx_active && rx_rise && (reply_cnt < reply_len_q);
    assign fsm_state = state;

    // Transmitter handshake: tx_start is a one-cycle pulse issued only while
    // tx_active is low; the byte is complete when tx_done pulses, and the next
    // start is issued no earlier than the cycle after that tx_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            args_q      <= '0;
            arg_cnt_q   <= '0;
            tx_idx      <= '0;
            reply_len_q <= '0;
            rx_prev     <= 1'b0;
            to_cnt      <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            reply_data  <= '0;
            reply_valid <= 1'b0;
            reply_cnt   <= '0;
            checksum    <= '0;
        end else begin
            tx_start    <= 1'b0;
            reply_valid <= 1'b0;
            rx_prev     <= rx_ready;

            if (state != ST_IDLE && !activate) begin
                // Aborted request; a byte already handed to the transmitter completes on its own.
                state <= ST_IDLE;
                done  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (activate) begin
                            cmd_q       <= cmd;
                            args_q      <= args;
                            arg_cnt_q   <= sat_arg_cnt(arg_cnt, MAX_A);
                            reply_len_q <= reply_len;
                            reply_cnt   <= '0;
                            checksum    <= '0;
                            timeout     <= 1'b0;
                            state       <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        tx_idx  <= '0;
                        tx_data <= cmd_q;
                        state   <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (!tx_active) begin
                            tx_start <= 1'b1;
                            state    <= ST_WAIT_TX;
                        end
                    end
                    ST_WAIT_TX: begin
                        if (tx_done) begin
                            if (tx_idx < arg_cnt_q) begin
                                tx_data <= 8'(args_q >> (8 * tx_idx));
                                tx_idx  <= tx_idx + 3'd1;
                                state   <= ST_SEND;
                            end else begin
                                state <= ST_FINISH;
                            end
                        end
                    end
                    ST_FINISH: begin
                        if (reply_cnt == reply_len_q) begin
                            done    <= 1'b1;
                            timeout <= 1'b0;
                            state   <= ST_DONE;
                        end else if (to_cnt >= TO_LAST) begin
                            done    <= 1'b1;
                            timeout <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end

            if (rx_accept) begin
                reply_data  <= rx_data;
                reply_valid <= 1'b1;
                reply_cnt   <= reply_cnt + 9'd1;
                checksum    <= checksum + rx_data;
            end

            // Inactivity counter saturates at its terminal value.
            if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (rx_accept || tx_done) begin
                to_cnt <= '0;
            end else if (to_cnt < TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
// Bench for cmd_initiator: transmitter and reply models, table of command
// sequences, plus abort, reset and idle-drop sequences.
module tb_cmd_initiator;
    import oscilo_pkg::*;

    localparam int TO     = 300;
    localparam int TX_LEN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       activate = 1'b0;
    logic [7:0] cmd = '0;
    logic [2:0] arg_cnt = '0;
    logic [31:0] args = '0;
    logic [8:0] reply_len = '0;
    logic       done;
    logic       timeout;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ready = 1'b0;
    logic [7:0] reply_data;
    logic       reply_valid;
    logic [8:0] reply_cnt;
    logic [7:0] checksum;
    logic [2:0] fsm_state;

    cmd_initiator #(.MAX_ARGS(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .activate(activate), .cmd(cmd), .arg_cnt(arg_cnt),
        .args(args), .reply_len(reply_len), .done(done), .timeout(timeout),
        .tx_data(tx_data), .tx_start(tx_start), .tx_active(tx_active), .tx_done(tx_done),
        .rx_data(rx_data), .rx_ready(rx_ready), .reply_data(reply_data),
        .reply_valid(reply_valid), .reply_cnt(reply_cnt), .checksum(checksum),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: expected event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // ---------------- scoreboard queues ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] rx_q[$];

    int last_rv_cyc = 0;
    int rv_count    = 0;

    always @(negedge clk) begin
        if (reply_valid) begin
            rv_count++;
            last_rv_cyc = cyc;
            if (exp_q.size() == 0) fail_now("reply_extra");
            else check("reply_data", reply_data, exp_q.pop_front());
        end
    end

    // ---------------- transmitter model ----------------
    int tx_busy   = 0;
    int tx_starts = 0;
    bit echo_en   = 1'b0;
    int echo_last = 0;

    always @(negedge clk) begin
        logic was_active;
        was_active = tx_active;
        if (tx_done) tx_done = 1'b0;
        if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) begin
                tx_active = 1'b0;
                tx_done   = 1'b1;
            end
        end
        if (tx_start) begin
            check("tx_start_idle", was_active, 1'b0);
            if (exp_tx_q.size() == 0) fail_now("tx_extra");
            else check("tx_byte", tx_data, exp_tx_q.pop_front());
            tx_active = 1'b1;
            tx_busy   = TX_LEN;
            if (echo_en && tx_starts > 0) begin
                rx_q.push_back(tx_data);
                if (tx_starts == echo_last) rx_q.push_back(8'h99);
            end
            tx_starts++;
        end
    end

    // ---------------- reply model ----------------
    int rx_hold = 0;
    int rx_gap  = 2;

    always @(negedge clk) begin
        if (rx_ready) rx_ready = 1'b0;
        else if (rx_hold > 0) rx_hold--;
        else if (rx_q.size() > 0) begin
            rx_data  = rx_q.pop_front();
            rx_ready = 1'b1;
            rx_hold  = rx_gap;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  cmd;
        logic [2:0]  ac;
        logic [31:0] args;
        logic [8:0]  rl;
        logic [7:0]  first;
        logic [7:0]  step;
        int          n;
        int          delay;
        bit          echo;
        bit          exp_to;
        logic [8:0]  exp_cnt;
        logic [7:0]  exp_sum;
    } vec_t;

    vec_t vecs[7];

    task automatic run_case(input int k);
        vec_t v;
        int n_tx;
        int finish_cyc;
        int done_cyc;
        logic [7:0] b;
        v = vecs[k];
        finish_cyc = -1;
        done_cyc   = -1;
        @(negedge clk);
        tx_starts = 0;
        echo_en   = v.echo;
        echo_last = int'(v.ac);
        n_tx = (v.ac > 3'd4) ? 4 : int'(v.ac);
        exp_tx_q.push_back(v.cmd);
        for (int i = 0; i < n_tx; i++) exp_tx_q.push_back(8'(v.args >> (8 * i)));
        if (v.echo) begin
            rx_gap = 1;
            for (int i = 0; i < int'(v.ac); i++) exp_q.push_back(8'(v.args >> (8 * i)));
        end else begin
            rx_gap  = 2;
            rx_hold = v.delay;
            for (int i = 0; i < v.n; i++) begin
                b = 8'(int'(v.first) + int'(v.step) * i);
                rx_q.push_back(b);
                if (i < int'(v.rl)) exp_q.push_back(b);
            end
        end
        cmd       = v.cmd;
        arg_cnt   = v.ac;
        args      = v.args;
        reply_len = v.rl;
        activate  = 1'b1;
        for (int w = 0; w < 4000 && done_cyc < 0; w++) begin
            @(negedge clk);
            if (fsm_state == ST_FINISH && finish_cyc < 0) finish_cyc = cyc;
            if (done) done_cyc = cyc;
        end
        if (done_cyc < 0) fail_now($sformatf("done_wait_case%0d", k));
        check($sformatf("timeout_case%0d", k), timeout, v.exp_to);
        check($sformatf("reply_cnt_case%0d", k), reply_cnt, v.exp_cnt);
        check($sformatf("checksum_case%0d", k), checksum, v.exp_sum);
        check($sformatf("reply_left_case%0d", k), exp_q.size(), 0);
        check($sformatf("tx_left_case%0d", k), exp_tx_q.size(), 0);
        if (v.exp_to) check($sformatf("to_latency_case%0d", k), done_cyc - last_rv_cyc, TO);
        if (v.rl == 9'd0) check($sformatf("finish_to_done_case%0d", k), done_cyc - finish_cyc, 1);
        activate = 1'b0;
        @(negedge clk);
        check($sformatf("done_clear_case%0d", k), done, 1'b0);
        check($sformatf("idle_after_case%0d", k), fsm_state, ST_IDLE);
        exp_q.delete();
        exp_tx_q.delete();
        rx_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int prev_cnt;
        int prev_rv;
        int starts_before;
        bit seen;

        vecs[0] = '{8'h24, 3'd0, 32'h0000_0000, 9'd1,   8'h5A, 8'h00, 1,   100, 1'b0, 1'b0, 9'd1,   8'h5A};
        vecs[1] = '{8'h32, 3'd2, 32'h0000_3412, 9'd0,   8'h00, 8'h00, 0,   0,   1'b0, 1'b0, 9'd0,   8'h00};
        vecs[2] = '{8'h22, 3'd0, 32'h0000_0000, 9'd256, 8'h00, 8'h01, 256, 20,  1'b0, 1'b0, 9'd256, 8'h80};
        vecs[3] = '{8'h21, 3'd0, 32'h0000_0000, 9'd3,   8'hA1, 8'h11, 2,   30,  1'b0, 1'b1, 9'd2,   8'h53};
        vecs[4] = '{8'h71, 3'd3, 32'h0033_2211, 9'd3,   8'h00, 8'h00, 0,   0,   1'b1, 1'b0, 9'd3,   8'h66};
        vecs[5] = '{8'h31, 3'd7, 32'h4433_2211, 9'd0,   8'h00, 8'h00, 0,   0,   1'b0, 1'b0, 9'd0,   8'h00};
        vecs[6] = '{8'h25, 3'd1, 32'h0000_00EE, 9'd2,   8'h10, 8'h01, 2,   5,   1'b0, 1'b0, 9'd2,   8'h21};

        // reset block
        #5 rst = 1'b0;
        #2;
        check("rst_ctrl", {done, timeout, tx_start, reply_valid, fsm_state}, 0);
        check("rst_data", {tx_data, reply_data, checksum}, 0);
        check("rst_cnt", reply_cnt, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) run_case(k);

        // rx edges while idle are dropped
        prev_cnt = int'(reply_cnt);
        prev_rv  = rv_count;
        rx_hold  = 0;
        rx_q.push_back(8'h77);
        repeat (8) @(negedge clk);
        check("idle_rx_cnt", reply_cnt, prev_cnt);
        check("idle_rx_pulses", rv_count, prev_rv);

        // abort while in SEND after the command byte
        tx_starts = 0;
        echo_en   = 1'b0;
        exp_tx_q.push_back(8'h32);
        cmd = 8'h32; arg_cnt = 3'd2; args = 32'h0000_3412; reply_len = 9'd0;
        activate = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge clk);
            if (fsm_state == ST_SEND && tx_starts >= 1) seen = 1'b1;
        end
        if (!seen) fail_now("abort_reach_send");
        activate = 1'b0;
        starts_before = tx_starts;
        @(negedge clk);
        check("abort_idle", fsm_state, ST_IDLE);
        check("abort_done", done, 1'b0);
        check("abort_tx_start", tx_start, 1'b0);
        repeat (20) @(negedge clk);
        check("abort_no_more_tx", tx_starts, starts_before);
        check("abort_tx_left", exp_tx_q.size(), 0);
        exp_tx_q.delete();

        // asynchronous reset while waiting on the transmitter
        tx_starts = 0;
        exp_tx_q.push_back(8'h21);
        cmd = 8'h21; arg_cnt = 3'd1; args = 32'h0000_00CC; reply_len = 9'd1;
        activate = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge clk);
            if (fsm_state == ST_WAIT_TX) seen = 1'b1;
        end
        if (!seen) fail_now("rst_reach_wait_tx");
        check("pre_rst_tx_data", tx_data, 8'h21);
        rst = 1'b0;
        #1;
        check("rst_wait_tx_data", tx_data, 8'h00);
        check("rst_wait_ctrl", {done, timeout, tx_start, reply_valid, fsm_state}, 0);
        check("rst_wait_cnt", {reply_cnt, checksum, reply_data}, 0);
        activate = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge clk);
            if (!tx_active && !tx_done) seen = 1'b1;
        end
        if (!seen) fail_now("rst_tx_drain");
        exp_tx_q.delete();
        rx_q.delete();
        exp_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // restart from IDLE after reset
        run_case(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
